neuron_feeder64: RTL and testbench

Streaming front end and result collector for the 64-input neuron unit. It accepts 8-bit activations one per cycle on a valid/ready stream and assembles them into the 64-element parallel vector that drives the neuron's `input_in`. It holds that vector stable for the neuron's fixed pipeline latency, then captures the neuron's 8-bit sigmoid output and presents it on a valid/ready result stream. Because the result format equals the input format, layers chain feeder → neuron → feeder.

---
 rtl/neuron_pkg.sv | 16 +
 rtl/neuron_feeder64_if.sv | 31 +++
 rtl/neuron_lat_timer.sv | 27 ++
 rtl/neuron_feeder64.sv | 140 ++++++++++++++
 tb/tb_neuron_feeder64.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/neuron_pkg.sv
// Shared types and constants for the neuron feeder: vector geometry,
// feeder FSM state encoding and the activation type.
package neuron_pkg;

  localparam int N_INPUTS = 64;
  localparam int DATA_W   = 8;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    WAIT   = 2'd1,
    RESULT = 2'd2
  } feeder_state_t;

  typedef logic [7:0] act_t;

endpackage

// File: rtl/neuron_feeder64_if.sv
// Activation input stream and result output stream of the neuron feeder.
//
// Handshake rule for both streams: a transfer happens on a rising clock edge
// where valid and ready are both 1. The source keeps valid, data and last
// stable until that edge; ready may be raised or lowered at any time and
// never depends combinationally on valid.
interface neuron_feeder64_if #(
  parameter int DATA_W = 8
);

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;

  // Upstream producer / downstream consumer side.
  modport master (
    output s_valid, s_data, s_last, res_ready,
    input  s_ready, res_valid, res_data
  );

  // Feeder side.
  modport slave (
    input  s_valid, s_data, s_last, res_ready,
    output s_ready, res_valid, res_data
  );

endinterface

// File: rtl/neuron_lat_timer.sv
// Loadable down-counter that models the neuron's fixed pipeline latency.
// done is high whenever the count has reached zero.
module neuron_lat_timer #(
  parameter int NEURON_LATENCY = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic done
);

  logic [3:0] count;

  // Load the latency on request, otherwise count down and stop at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 4'd0;
    end else if (load) begin
      count <= 4'(NEURON_LATENCY);
    end else if (count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign done = (count == 4'd0);

endmodule

// File: rtl/neuron_feeder64.sv
// Streaming front end for the 64-input neuron: serial activations are
// assembled into the parallel vector, held for the neuron latency, and the
// neuron's 8-bit output is returned on a valid/ready result stream.
module neuron_feeder64 #(
  parameter int N_INPUTS       = neuron_pkg::N_INPUTS,
  parameter int DATA_W         = neuron_pkg::DATA_W,
  parameter int NEURON_LATENCY = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  neuron_feeder64_if.slave              bus,
  output logic [31:0]                   vec_out [N_INPUTS],
  input  logic [31:0]                   neuron_out,
  output logic                          err_frame,
  output neuron_pkg::feeder_state_t     dbg_state,
  output logic [$clog2(N_INPUTS)-1:0]   dbg_idx
);

  import neuron_pkg::*;

  localparam int                IDX_W    = $clog2(N_INPUTS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_INPUTS - 1);

  feeder_state_t    state;
  feeder_state_t    state_nxt;
  logic [IDX_W-1:0] idx;
  logic             accept;
  logic             complete;
  logic             timer_load;
  logic             timer_done;
  logic             capture;
  act_t             res_q;

  // Only the low byte of the neuron output carries the sigmoid result.
  logic unused_neuron_hi;
  assign unused_neuron_hi = ^neuron_out[31:DATA_W];

  neuron_lat_timer #(
    .NEURON_LATENCY (NEURON_LATENCY)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (timer_load),
    .done  (timer_done)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs; vectors never overlap, so s_ready is
  // only high while filling.
  always_comb begin
    state_nxt     = state;
    bus.s_ready   = 1'b0;
    bus.res_valid = 1'b0;
    accept        = 1'b0;
    complete      = 1'b0;
    timer_load    = 1'b0;
    capture       = 1'b0;
    case (state)
      FILL: begin
        bus.s_ready = 1'b1;
        accept      = bus.s_valid;
        complete    = bus.s_valid && (bus.s_last || (idx == LAST_IDX));
        if (complete) begin
          timer_load = 1'b1;
          state_nxt  = WAIT;
        end
      end
      WAIT: begin
        if (timer_done) begin
          capture   = 1'b1;
          state_nxt = RESULT;
        end
      end
      RESULT: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) begin
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  // Element index: advances per accept, wraps to 0 when a vector completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (accept) begin
      idx <= complete ? '0 : idx + 1'b1;
    end
  end

  // Vector register: write the accepted element; an early last clears the tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_INPUTS; i++) begin
        vec_out[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < N_INPUTS; i++) begin
        if (IDX_W'(i) == idx) begin
          vec_out[i] <= {{(32-DATA_W){1'b0}}, bus.s_data};
        end else if (bus.s_last && (IDX_W'(i) > idx)) begin
          vec_out[i] <= '0;
        end
      end
    end
  end

  // Framing error: the final slot was filled without s_last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_frame <= 1'b0;
    end else begin
      err_frame <= accept && (idx == LAST_IDX) && !bus.s_last;
    end
  end

  // Result register: sample the neuron once its latency has elapsed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
    end else if (capture) begin
      res_q <= neuron_out[DATA_W-1:0];
    end
  end

  assign bus.res_data = res_q;
  assign dbg_state    = state;
  assign dbg_idx      = idx;

endmodule

// File: tb/tb_neuron_feeder64.sv
// Directed bench for neuron_feeder64 with a 5-stage neuron stand-in whose
// output is (sum of element low bytes) ^ 8'h85, upper bits filled with junk.
module tb_neuron_feeder64;

  import neuron_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  neuron_feeder64_if #(.DATA_W(8)) bus ();

  logic [31:0]   vec_out [64];
  logic [31:0]   neuron_out;
  logic          err_frame;
  feeder_state_t dbg_state;
  logic [5:0]    dbg_idx;

  neuron_feeder64 #(
    .N_INPUTS       (64),
    .DATA_W         (8),
    .NEURON_LATENCY (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .vec_out    (vec_out),
    .neuron_out (neuron_out),
    .err_frame  (err_frame),
    .dbg_state  (dbg_state),
    .dbg_idx    (dbg_idx)
  );

  // ---------------- neuron stand-in ----------------
  logic [7:0] nsum;
  logic [7:0] pipe [5];

  always_comb begin
    nsum = 8'd0;
    for (int i = 0; i < 64; i++) nsum = nsum + vec_out[i][7:0];
  end

  initial for (int k = 0; k < 5; k++) pipe[k] = 8'd0;

  always @(posedge clk) begin
    pipe[0] <= nsum ^ 8'h85;
    for (int k = 1; k < 5; k++) pipe[k] <= pipe[k-1];
  end

  assign neuron_out = {24'h5A5A5A, pipe[4]};

  // ---------------- scoreboard state ----------------
  int         checks   = 0;
  int         failures = 0;
  int         err_cnt  = 0;
  int         exp_err  = 0;
  logic [7:0] exp_q [$];
  logic [31:0] exp_vec [64];

  always @(negedge clk) if (err_frame) err_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_res();
    logic [7:0] s;
    s = 8'd0;
    for (int i = 0; i < 64; i++) s = s + exp_vec[i][7:0];
    return s ^ 8'h85;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    logic took;
    int   n;
    took        = 1'b0;
    n           = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    while (!took && n < 200) begin
      took = bus.s_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    chk("send_accept", 32'(took), 32'd1);
  endtask

  // mode: 0 -> i+1, 1 -> 255, 2 -> 7, 3 -> 3*i, 4 -> random, 5 -> i+100
  task automatic send_vector(input int len, input bit with_last, input int mode,
                             input bit gaps, input int hand);
    logic [7:0] d;
    for (int i = 0; i < len; i++) begin
      case (mode)
        0:       d = 8'(i + 1);
        1:       d = 8'd255;
        2:       d = 8'd7;
        3:       d = 8'(3 * i);
        4:       d = 8'($urandom_range(0, 255));
        default: d = 8'(i + 100);
      endcase
      exp_vec[i] = {24'd0, d};
      if (gaps && ($urandom_range(0, 1) == 1)) idle(1);
      send(d, with_last && (i == len - 1));
    end
    for (int j = len; j < 64; j++) exp_vec[j] = 32'd0;
    if (hand >= 0) exp_q.push_back(8'(hand));
    else           exp_q.push_back(model_res());
  endtask

  task automatic chk_vec(input string tag);
    for (int i = 0; i < 64; i++) chk(tag, vec_out[i], exp_vec[i]);
  endtask

  task automatic wait_res(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    while (!bus.res_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk(tag, 32'(lat), 32'(exp_lat));
  endtask

  task automatic take_res(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s got=%0h exp=<empty queue>", tag, bus.res_data);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'(bus.res_data), 32'(e));
    end
    chk("res_valid_before_hs", 32'(bus.res_valid), 32'd1);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    chk("s_ready_after_hs", 32'(bus.s_ready), 32'd1);
    chk("res_valid_after_hs", 32'(bus.res_valid), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.s_valid   = 1'b0;
    bus.s_data    = 8'd0;
    bus.s_last    = 1'b0;
    bus.res_ready = 1'b0;
    for (int i = 0; i < 64; i++) exp_vec[i] = 32'd0;

    // reset values
    #1;
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_err", 32'(err_frame), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_s_ready", 32'(bus.s_ready), 32'd1);
    chk("rst_res_data", 32'(bus.res_data), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(FILL));
    chk("rst_idx", 32'(dbg_idx), 32'd0);
    chk_vec("rst_vec");

    // full vector 1..64: sum 2080 -> low byte 0x20, ^0x85 = 0xA5
    send_vector(64, 1'b1, 0, 1'b0, 'hA5);
    chk("full_state_wait", 32'(dbg_state), 32'(WAIT));
    chk("full_s_ready_wait", 32'(bus.s_ready), 32'd0);
    chk_vec("full_vec");
    wait_res("full_latency", 6);
    take_res("full_res");
    chk("full_no_err", 32'(err_cnt), 32'(exp_err));

    // all-255 vector: 64*255 = 16320 -> 0xC0, ^0x85 = 0x45
    send_vector(64, 1'b1, 1, 1'b0, 'h45);
    chk_vec("all255_vec");
    wait_res("all255_latency", 6);
    take_res("all255_res");

    // short vector of ten 7s: sum 70 = 0x46, ^0x85 = 0xC3; tail cleared
    send_vector(10, 1'b1, 2, 1'b0, 'hC3);
    chk("short_state_wait", 32'(dbg_state), 32'(WAIT));
    chk("short_idx_reset", 32'(dbg_idx), 32'd0);
    chk_vec("short_vec");
    wait_res("short_latency", 6);
    take_res("short_res");
    chk("short_no_err", 32'(err_cnt), 32'(exp_err));

    // missing last: 3*i, sum 6048 -> 0xA0, ^0x85 = 0x25
    send_vector(64, 1'b0, 3, 1'b0, 'h25);
    chk("miss_err_high", 32'(err_frame), 32'd1);
    exp_err++;
    idle(1);
    chk("miss_err_low", 32'(err_frame), 32'd0);
    chk("miss_err_count", 32'(err_cnt), 32'(exp_err));
    chk_vec("miss_vec");
    wait_res("miss_latency", 5);

    // backpressure with s_valid held high during RESULT
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h5A;
    bus.s_last  = 1'b0;
    for (int c = 0; c < 20; c++) begin
      chk("bp_s_ready", 32'(bus.s_ready), 32'd0);
      chk("bp_res_data", 32'(bus.res_data), 32'(exp_q[0]));
      idle(1);
    end
    chk("bp_vec0_held", vec_out[0], exp_vec[0]);
    chk("bp_res_final", 32'(bus.res_data), 32'(exp_q.pop_front()));
    bus.res_ready = 1'b1;
    idle(1);
    bus.res_ready = 1'b0;
    chk("bp_s_ready_R", 32'(bus.s_ready), 32'd1);
    chk("bp_vec0_still_old", vec_out[0], exp_vec[0]);
    idle(1);
    chk("bp_accept_R1", vec_out[0], 32'h5A);
    chk("bp_idx_R1", 32'(dbg_idx), 32'd1);
    bus.s_data = 8'h11;
    bus.s_last = 1'b1;
    idle(1);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    // 0x5A + 0x11 = 0x6B, ^0x85 = 0xEE
    exp_vec[0] = 32'h5A;
    exp_vec[1] = 32'h11;
    for (int j = 2; j < 64; j++) exp_vec[j] = 32'd0;
    exp_q.push_back(8'hEE);
    chk_vec("bp_vec");
    wait_res("bp_latency", 6);
    take_res("bp_res");

    // bubbles over three random vectors
    send_vector(64, 1'b1, 4, 1'b1, -1);
    chk_vec("bub0_vec");
    wait_res("bub0_latency", 6);
    idle($urandom_range(0, 3));
    take_res("bub0_res");
    send_vector(20, 1'b1, 4, 1'b1, -1);
    chk_vec("bub1_vec");
    wait_res("bub1_latency", 6);
    idle($urandom_range(0, 3));
    take_res("bub1_res");
    send_vector(64, 1'b0, 4, 1'b1, -1);
    exp_err++;
    chk_vec("bub2_vec");
    wait_res("bub2_latency", 6);
    take_res("bub2_res");
    chk("bub_err_count", 32'(err_cnt), 32'(exp_err));

    // reset in the middle of FILL at idx 30
    for (int i = 0; i < 30; i++) send(8'(200 + i), 1'b0);
    chk("midfill_idx", 32'(dbg_idx), 32'd30);
    #3;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 64; i++) exp_vec[i] = 32'd0;
    chk_vec("midfill_rst_vec");
    chk("midfill_rst_idx", 32'(dbg_idx), 32'd0);
    chk("midfill_rst_s_ready", 32'(bus.s_ready), 32'd1);
    chk("midfill_rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("midfill_rst_res_data", 32'(bus.res_data), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    // i+100: sum 8416 -> 0xE0, ^0x85 = 0x65
    send_vector(64, 1'b1, 5, 1'b0, 'h65);
    chk_vec("midfill_fresh_vec");
    wait_res("midfill_fresh_latency", 6);
    take_res("midfill_fresh_res");

    // reset in the middle of WAIT
    send_vector(5, 1'b1, 2, 1'b0, -1);
    idle(2);
    chk("midwait_state", 32'(dbg_state), 32'(WAIT));
    #3;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_vec[i] = 32'd0;
    chk("midwait_rst_state", 32'(dbg_state), 32'(FILL));
    chk("midwait_rst_s_ready", 32'(bus.s_ready), 32'd1);
    chk("midwait_rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("midwait_rst_err", 32'(err_frame), 32'd0);
    chk_vec("midwait_rst_vec");
    repeat (10) @(posedge clk);
    #1;
    chk("midwait_no_result", 32'(bus.res_valid), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_vector(64, 1'b1, 5, 1'b0, 'h65);
    chk_vec("midwait_fresh_vec");
    wait_res("midwait_fresh_latency", 6);
    take_res("midwait_fresh_res");

    // final bookkeeping
    chk("err_total", 32'(err_cnt), 32'(exp_err));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
